// File: rtl/spi_display_receiver.sv
// SPI display-link receiver: synchronizes the 4-wire pins, reassembles MSB-first bytes
// tagged with D/C, and queues them in a small first-word-fall-through FIFO.
module spi_display_receiver #(
    parameter int FIFO_DEPTH  = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        sclk,
    input  logic                        cs_n,
    input  logic                        din,
    input  logic                        dc,
    input  logic                        rst_n,
    output logic [7:0]                  rx_data,
    output logic                        rx_dc,
    output logic                        rx_valid,
    input  logic                        rx_ready,
    output logic [$clog2(FIFO_DEPTH):0] level,
    output logic                        overflow,
    output logic                        frame_err,
    input  logic                        clr_status,
    output logic                        busy
);

    localparam int AW = $clog2(FIFO_DEPTH);
    // Pin order {rst_n, cs_n, dc, din, sclk}; the active-low pins idle high.
    localparam logic [4:0] SYNC_INIT = 5'b11000;

    typedef enum logic {IDLE, SHIFT} state_t;

    logic [4:0] pins;
    logic [4:0] pins_sync;
    assign pins = {rst_n, cs_n, dc, din, sclk};

    genvar gi;
    generate
        for (gi = 0; gi < 5; gi++) begin : g_sync
            logic [SYNC_STAGES-1:0] chain_reg;
            always_ff @(posedge clk or posedge reset) begin
                if (reset)
                    chain_reg <= {SYNC_STAGES{SYNC_INIT[gi]}};
                else
                    chain_reg <= {chain_reg[SYNC_STAGES-2:0], pins[gi]};
            end
            assign pins_sync[gi] = chain_reg[SYNC_STAGES-1];
        end
    endgenerate

    logic sclk_sync, din_sync, dc_sync, cs_sync, rst_n_sync;
    assign sclk_sync  = pins_sync[0];
    assign din_sync   = pins_sync[1];
    assign dc_sync    = pins_sync[2];
    assign cs_sync    = pins_sync[3];
    assign rst_n_sync = pins_sync[4];

    // One extra aligned stage: the sclk edge pulse and the pins it qualifies
    // are registered together so the shifter sees a coherent snapshot.
    logic sclk_prev_reg, rise_reg, din_reg, dc_reg, cs_reg, cs_prev_reg;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sclk_prev_reg <= 1'b0;
            rise_reg      <= 1'b0;
            din_reg       <= 1'b0;
            dc_reg        <= 1'b0;
            cs_reg        <= 1'b1;
            cs_prev_reg   <= 1'b1;
        end else begin
            sclk_prev_reg <= sclk_sync;
            rise_reg      <= sclk_sync & ~sclk_prev_reg;
            din_reg       <= din_sync;
            dc_reg        <= dc_sync;
            cs_reg        <= cs_sync;
            cs_prev_reg   <= cs_reg;
        end
    end

    state_t     state_reg;
    logic [7:0] shift_reg;
    logic [2:0] bitcnt_reg;
    logic [AW:0] wr_ptr_reg, rd_ptr_reg;
    logic [8:0] mem [FIFO_DEPTH];
    logic [8:0] head;
    logic       overflow_reg, frame_err_reg;
    logic       push_req, push_ok, pop, full, frame_evt, ovf_evt;

    assign level     = wr_ptr_reg - rd_ptr_reg;
    assign rx_valid  = (level != '0);
    assign full      = (level == (AW+1)'(FIFO_DEPTH));
    assign pop       = rx_valid & rx_ready;
    assign push_req  = rst_n_sync && (state_reg == SHIFT) && !cs_reg && rise_reg && (bitcnt_reg == 3'd7);
    assign push_ok   = push_req && (!full || pop);
    assign ovf_evt   = push_req && full && !pop;
    assign frame_evt = rst_n_sync && (state_reg == SHIFT) && cs_reg && (bitcnt_reg != 3'd0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg  <= IDLE;
            shift_reg  <= '0;
            bitcnt_reg <= '0;
        end else if (!rst_n_sync) begin
            state_reg  <= IDLE;
            shift_reg  <= '0;
            bitcnt_reg <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (!cs_reg && cs_prev_reg)
                        state_reg <= SHIFT;
                end
                SHIFT: begin
                    if (cs_reg) begin
                        bitcnt_reg <= '0;
                        state_reg  <= IDLE;
                    end else if (rise_reg) begin
                        shift_reg  <= {shift_reg[6:0], din_reg};
                        bitcnt_reg <= bitcnt_reg + 3'd1;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok)
            mem[wr_ptr_reg[AW-1:0]] <= {dc_reg, shift_reg[6:0], din_reg};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else if (!rst_n_sync) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (push_ok)
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop)
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
        end
    end

    // A new event in the same cycle as clr_status keeps its flag set.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overflow_reg  <= 1'b0;
            frame_err_reg <= 1'b0;
        end else begin
            if (ovf_evt)
                overflow_reg <= 1'b1;
            else if (clr_status)
                overflow_reg <= 1'b0;
            if (frame_evt)
                frame_err_reg <= 1'b1;
            else if (clr_status)
                frame_err_reg <= 1'b0;
        end
    end

    assign head      = mem[rd_ptr_reg[AW-1:0]];
    assign rx_data   = rx_valid ? head[7:0] : 8'h00;
    assign rx_dc     = rx_valid ? head[8] : 1'b0;
    assign overflow  = overflow_reg;
    assign frame_err = frame_err_reg;
    assign busy      = !cs_reg || (bitcnt_reg != 3'd0);

endmodule

// File: tb/tb_spi_display_receiver.sv
// Bench for spi_display_receiver: table-driven single bytes, hand-written corner
// sequences, then random frames checked against a queue-based model.
module tb_spi_display_receiver;

    localparam int DEPTH = 4;
    localparam int SYNC  = 2;

    logic clk = 1'b0, reset = 1'b1, sclk = 1'b0, cs_n = 1'b1, din = 1'b0, dc = 1'b0;
    logic rst_n = 1'b1, rx_ready = 1'b0, clr_status = 1'b0;
    logic [7:0] rx_data;
    logic rx_dc, rx_valid, overflow, frame_err, busy;
    logic [$clog2(DEPTH):0] level;

    int checks = 0;
    int errors = 0;

    spi_display_receiver #(.FIFO_DEPTH(DEPTH), .SYNC_STAGES(SYNC)) dut (
        .clk(clk), .reset(reset), .sclk(sclk), .cs_n(cs_n), .din(din), .dc(dc),
        .rst_n(rst_n), .rx_data(rx_data), .rx_dc(rx_dc), .rx_valid(rx_valid),
        .rx_ready(rx_ready), .level(level), .overflow(overflow), .frame_err(frame_err),
        .clr_status(clr_status), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] b;
        logic       d;
        logic [7:0] exp_data;
        logic       exp_dc;
        int         exp_lat;
    } vec_t;

    vec_t tbl [5];
    bit [8:0] q [$];
    bit m_ovf, m_ferr;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end else begin
            $display("ok   %s: %0h", name, act);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic spi_bit(input logic b);
        sclk = 1'b0;
        din  = b;
        cyc(2);
        sclk = 1'b1;
        cyc(2);
    endtask

    task automatic cs_low();
        cs_n = 1'b0;
        cyc(4);
    endtask

    task automatic cs_high();
        cs_n = 1'b1;
        cyc(5);
    endtask

    // Last bit: count clk edges after the sclk rise until level changes; optional
    // one-cycle pop aimed at edge pop_at.
    task automatic send_byte(input logic [7:0] b, input logic d, input int pop_at, output int lat);
        int lv;
        dc = d;
        for (int i = 7; i >= 1; i--)
            spi_bit(b[i]);
        sclk = 1'b0;
        din  = b[0];
        cyc(2);
        lv   = int'(level);
        sclk = 1'b1;
        lat  = -1;
        for (int c = 1; c <= 6; c++) begin
            if (c == pop_at)
                rx_ready = 1'b1;
            @(posedge clk);
            #1;
            rx_ready = 1'b0;
            if (lat < 0 && int'(level) != lv)
                lat = c;
        end
    endtask

    task automatic do_pop();
        rx_ready = 1'b1;
        cyc(1);
        rx_ready = 1'b0;
    endtask

    task automatic pulse_clr();
        clr_status = 1'b1;
        cyc(1);
        clr_status = 1'b0;
        cyc(1);
    endtask

    task automatic chk_head(input string tag, input logic [7:0] d, input logic f, input int lv);
        chk({tag, " data"}, rx_data, d);
        chk({tag, " dc"}, rx_dc, f);
        chk({tag, " level"}, level, lv);
    endtask

    task automatic check_model(input string tag);
        chk({tag, " level"}, level, q.size());
        chk({tag, " valid"}, rx_valid, q.size() != 0);
        if (q.size() != 0) begin
            chk({tag, " data"}, rx_data, q[0][7:0]);
            chk({tag, " dc"}, rx_dc, q[0][8]);
        end
        chk({tag, " overflow"}, overflow, m_ovf);
        chk({tag, " frame_err"}, frame_err, m_ferr);
    endtask

    initial begin
        int lat, cnt;
        logic [7:0] rb;
        logic rd;

        tbl[0] = '{8'hAF, 1'b0, 8'hAF, 1'b0, SYNC + 2};
        tbl[1] = '{8'h00, 1'b1, 8'h00, 1'b1, SYNC + 2};
        tbl[2] = '{8'hFF, 1'b0, 8'hFF, 1'b0, SYNC + 2};
        tbl[3] = '{8'h5A, 1'b1, 8'h5A, 1'b1, SYNC + 2};
        tbl[4] = '{8'hA5, 1'b0, 8'hA5, 1'b0, SYNC + 2};

        // Reset state
        cyc(3);
        chk("rst rx_valid", rx_valid, 0);
        chk("rst rx_data", rx_data, 0);
        chk("rst rx_dc", rx_dc, 0);
        chk("rst level", level, 0);
        chk("rst busy", busy, 0);
        chk("rst overflow", overflow, 0);
        chk("rst frame_err", frame_err, 0);
        reset = 1'b0;
        cyc(2);

        // Single-byte table
        for (int i = 0; i < 5; i++) begin
            cs_low();
            send_byte(tbl[i].b, tbl[i].d, 0, lat);
            cs_high();
            chk("tbl latency", lat, tbl[i].exp_lat);
            chk_head("tbl", tbl[i].exp_data, tbl[i].exp_dc, 1);
            do_pop();
            chk("tbl level after pop", level, 0);
        end

        // 16-bit data word splits high byte first
        cs_low();
        send_byte(8'hF8, 1'b1, 0, lat);
        chk("w16 busy", busy, 1);
        send_byte(8'h1F, 1'b1, 0, lat);
        cs_high();
        chk_head("w16 first", 8'hF8, 1'b1, 2);
        do_pop();
        chk_head("w16 second", 8'h1F, 1'b1, 1);
        do_pop();
        chk("w16 empty", level, 0);

        // Overflow: fifth byte dropped, then cleared
        cs_low();
        for (int i = 1; i <= DEPTH + 1; i++)
            send_byte(8'(i), 1'b0, 0, lat);
        cs_high();
        chk("ovf flag", overflow, 1);
        chk_head("ovf head", 8'h01, 1'b0, DEPTH);
        pulse_clr();
        chk("ovf cleared", overflow, 0);
        for (int i = 1; i <= DEPTH; i++) begin
            chk("ovf drain", rx_data, i);
            do_pop();
        end
        chk("ovf empty", level, 0);

        // Full FIFO with a pop on the push edge
        cs_low();
        for (int i = 1; i <= DEPTH; i++)
            send_byte(8'(i), 1'b0, 0, lat);
        send_byte(8'h05, 1'b0, SYNC + 2, lat);
        cs_high();
        chk("fullpop overflow", overflow, 0);
        chk_head("fullpop head", 8'h02, 1'b0, DEPTH);
        for (int i = 2; i <= DEPTH + 1; i++) begin
            chk("fullpop drain", rx_data, i);
            do_pop();
        end
        chk("fullpop empty", level, 0);

        // Partial byte then a clean byte
        cs_low();
        for (int i = 0; i < 5; i++)
            spi_bit(i[0]);
        chk("partial busy", busy, 1);
        cs_high();
        chk("partial frame_err", frame_err, 1);
        chk("partial level", level, 0);
        chk("partial busy idle", busy, 0);
        cs_low();
        send_byte(8'h3C, 1'b1, 0, lat);
        cs_high();
        chk_head("after partial", 8'h3C, 1'b1, 1);
        pulse_clr();
        chk("frame_err cleared", frame_err, 0);
        do_pop();

        // rst_n flush keeps sticky flags
        cs_low();
        for (int i = 0; i < 3; i++)
            send_byte(8'h40 + 8'(i), 1'b0, 0, lat);
        for (int i = 0; i < 3; i++)
            spi_bit(1'b1);
        cs_high();
        chk("flush pre level", level, 3);
        chk("flush pre frame_err", frame_err, 1);
        rst_n = 1'b0;
        cnt = -1;
        for (int c = 1; c <= 8; c++) begin
            cyc(1);
            if (cnt < 0 && level == 0)
                cnt = c;
        end
        chk("flush within bound", (cnt > 0 && cnt <= SYNC + 1), 1);
        chk("flush rx_valid", rx_valid, 0);
        chk("flush frame_err kept", frame_err, 1);
        rst_n = 1'b1;
        cyc(4);
        pulse_clr();

        // Asynchronous reset mid-byte
        cs_low();
        send_byte(8'h11, 1'b0, 0, lat);
        for (int i = 0; i < 3; i++)
            spi_bit(1'b0);
        chk("areset pre level", level, 1);
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        chk("areset rx_valid", rx_valid, 0);
        chk("areset level", level, 0);
        chk("areset busy", busy, 0);
        chk("areset rx_data", rx_data, 0);
        #1;
        reset = 1'b0;
        cs_n  = 1'b1;
        cyc(5);
        cs_low();
        send_byte(8'h66, 1'b1, 0, lat);
        cs_high();
        chk_head("areset next", 8'h66, 1'b1, 1);
        do_pop();

        // Random frames against the queue model
        q.delete();
        m_ovf  = 1'b0;
        m_ferr = 1'b0;
        for (int t = 0; t < 40; t++) begin
            case ($urandom_range(0, 5))
                0, 1, 2: begin
                    cs_low();
                    for (int k = 0; k < int'($urandom_range(1, 3)); k++) begin
                        rb = 8'($urandom);
                        rd = 1'($urandom);
                        send_byte(rb, rd, 0, lat);
                        if (q.size() < DEPTH)
                            q.push_back({rd, rb});
                        else
                            m_ovf = 1'b1;
                    end
                    cs_high();
                end
                3: begin
                    cs_low();
                    for (int k = 0; k < int'($urandom_range(1, 7)); k++)
                        spi_bit(1'($urandom));
                    cs_high();
                    m_ferr = 1'b1;
                end
                4: begin
                    do_pop();
                    if (q.size() != 0)
                        void'(q.pop_front());
                end
                default: begin
                    pulse_clr();
                    m_ovf  = 1'b0;
                    m_ferr = 1'b0;
                end
            endcase
            check_model("rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/spi_display_receiver.md
Name: spi_display_receiver

Overview:
- SPI peripheral-side receiver for the 4-wire display link: serial data in, serial clock, active-low chip select, and data/command select.
- Samples the serial data stream MSB-first and reassembles bytes, each tagged with its D/C flag.
- Buffers bytes in a small FWFT FIFO for a system-side consumer.
- Used as a display model or bridge in loopback and SoC simulation, and to let a soft core emulate a display.

Parameters:
- FIFO_DEPTH, 4, entries in receive FIFO; power of two, ≥2.
- SYNC_STAGES, 2, flip-flop stages on each asynchronous pin input; ≥2.

Ports:
- clk  in  1  system clock; must be ≥4× SCLK frequency.
- reset  in  1  asynchronous, active-high reset.
- sclk  in  1  serial clock from transmitter; idle level don't-care.
- cs_n  in  1  chip select, active low.
- din  in  1  serial data, MSB first.
- dc  in  1  1 = data byte, 0 = command byte.
- rst_n  in  1  display reset pin, active low.
- rx_data  out  8  head-of-FIFO byte.
- rx_dc  out  1  D/C flag of head byte.
- rx_valid  out  1  FIFO non-empty.
- rx_ready  in  1  consumer pop; pop occurs when rx_valid && rx_ready.
- level  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy.
- overflow  out  1  sticky: a completed byte was dropped because the FIFO was full.
- frame_err  out  1  sticky: cs_n rose with a partial byte pending.
- clr_status  in  1  one-cycle pulse clears overflow and frame_err.
- busy  out  1  cs_n (synchronized) low or partial byte pending.

Behaviour:
- Reset (asynchronous, active-high) clears:
  - all synchronizers: sclk/din/dc sync to 0, cs_n and rst_n sync to 1;
  - shift register, bit counter (0), FIFO pointers;
  - overflow, frame_err.
- Outputs during reset: rx_valid=0, rx_data=0, rx_dc=0, level=0, busy=0.
- Synchronization and edge detect:
  - All five pin inputs pass through SYNC_STAGES flip-flops.
  - Rising SCLK edge is detected as synchronized sclk=1 while the previous sample was 0.
- Shift states: IDLE (cs_n high) and SHIFT (cs_n low).
  - IDLE→SHIFT on synchronized cs_n falling.
  - In SHIFT, each rising sclk edge: shift = {shift[6:0], din_sync}, bitcnt+1.
  - The 8th edge pushes {dc_sync, byte} into the FIFO and sets bitcnt=0. Stay in SHIFT for back-to-back bytes.
  - A 16-bit data transfer therefore yields two FIFO entries, high byte first.
- SHIFT→IDLE on synchronized cs_n rising.
  - bitcnt≠0: discard the partial byte, set frame_err, bitcnt=0.
  - bitcnt=0: no flag.
- Rising sclk edges while cs_n is high are ignored.
- Latency: rx_valid (empty FIFO) asserts exactly SYNC_STAGES+2 clk cycles after the 8th sclk rising edge at the pin.
- FIFO:
  - First-word-fall-through; rx_data/rx_dc are valid whenever rx_valid=1.
  - Pointers wrap modulo FIFO_DEPTH.
  - level = write count − read count, range 0..FIFO_DEPTH.
- Full:
  - Push with no pop in the same cycle: byte dropped, overflow set, level unchanged.
  - Push with a pop in the same cycle: both succeed, level unchanged, no overflow.
- Empty: rx_ready ignored, level stays 0.
- Push and pop in the same cycle when non-full and non-empty: level unchanged.
- clr_status coinciding with a new overflow or frame_err event: the event wins and the flag stays set.
- Synchronized rst_n low, held as a level:
  - Flushes FIFO (level=0, rx_valid=0), clears shift state and bitcnt, forces IDLE.
  - Pushes are blocked while low.
  - Sticky flags are preserved.
- Reset asserted mid-byte: everything clears immediately; the next byte starts fresh after cs_n high→low.

Test Plan:
- Command 0xAF (dc=0) at SCLK=clk/4 -> exactly one entry rx_data=0xAF, rx_dc=0; rx_valid rises SYNC_STAGES+2 cycles after the 8th edge; level=1.
- 16-bit data 0xF81F (dc=1), rx_ready=0 -> entries 0xF8 then 0x1F, both rx_dc=1; level=2; popping yields same order.
- FIFO_DEPTH+1 bytes 0x01..0x05 (depth 4) with rx_ready=0 -> 0x01..0x04 held, 0x05 dropped, overflow=1, level=4. clr_status -> overflow=0.
- Full FIFO with rx_ready=1 in the same cycle the 5th byte completes -> no overflow; level stays 4; head advances to 0x02.
- cs_n rises after 5 bits -> no push, frame_err=1; the following full byte 0x3C is received correctly.
- rst_n low with 3 bytes queued -> level=0, rx_valid=0 within SYNC_STAGES+1 cycles; async reset mid-byte -> all outputs 0 in the same cycle.
